// File: rtl/sgsc_pkg.sv
// Shared types and width helpers for the streaming group-sum classifier.
package sgsc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        AVG,
        ARG,
        OUT
    } state_e;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits needed to index n items; never narrower than one bit.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/streaming_group_sum_classifier_chunk_popcount.sv
// Combinational population count of one CHUNK_W-bit slice of a class group.
module chunk_popcount
    import sgsc_pkg::*;
#(
    parameter int W = 100,
    localparam int OW = count_width(W)
) (
    input  logic [W-1:0]  bits_i,
    output logic [OW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + OW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/streaming_group_sum_classifier.sv
// Classifier back end: serial per-class popcount, per-class EMA, registered argmax
// with a valid/ready result port.
module streaming_group_sum_classifier
    import sgsc_pkg::*;
#(
    parameter int NET_WIDTH   = 8000,
    parameter int NUM_CLASSES = 10,
    parameter int NUM_CHUNKS  = 8,
    parameter int MA_SHIFT    = 2,
    parameter int ACC_W       = 16,
    localparam int IDX_W      = index_width(NUM_CLASSES)
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic [NET_WIDTH-1:0]   net_i,
    input  logic                   inp_valid_i,
    output logic                   inp_ready_o,
    input  logic                   clear_i,
    output logic [IDX_W-1:0]       class_idx_o,
    output logic [NUM_CLASSES-1:0] class_onehot_o,
    output logic [ACC_W-1:0]       score_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i
);

    localparam int GROUP_SIZE = NET_WIDTH / NUM_CLASSES;
    localparam int CHUNK_W    = GROUP_SIZE / NUM_CHUNKS;
    localparam int CNT_W      = count_width(GROUP_SIZE);
    localparam int PC_W       = count_width(CHUNK_W);
    localparam int CHK_W      = index_width(NUM_CHUNKS);

    if (NET_WIDTH % NUM_CLASSES != 0) begin : g_bad_group
        $error("NET_WIDTH must be a multiple of NUM_CLASSES");
    end
    if (GROUP_SIZE % NUM_CHUNKS != 0) begin : g_bad_chunk
        $error("GROUP_SIZE must be a multiple of NUM_CHUNKS");
    end
    if (ACC_W < CNT_W + MA_SHIFT) begin : g_bad_acc
        $error("ACC_W too narrow for CNT_W + MA_SHIFT");
    end

    state_e                 state_q, state_d;
    logic [NET_WIDTH-1:0]   net_q;
    logic [CHK_W-1:0]       chunk_q;
    logic [CNT_W-1:0]       count_q [NUM_CLASSES];
    logic [ACC_W-1:0]       acc_q   [NUM_CLASSES];
    logic [PC_W-1:0]        pc      [NUM_CLASSES];
    logic [IDX_W-1:0]       class_idx_q, best_idx;
    logic [NUM_CLASSES-1:0] onehot_q;
    logic [ACC_W-1:0]       score_q, best_score;
    logic                   out_valid_q;
    logic                   in_fire;

    assign inp_ready_o    = (state_q == IDLE) && reset_ni;
    assign in_fire        = inp_valid_i && inp_ready_o;
    assign class_idx_o    = class_idx_q;
    assign class_onehot_o = onehot_q;
    assign score_o        = score_q;
    assign out_valid_o    = out_valid_q;

    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_class
        logic [CHUNK_W-1:0] chunks [NUM_CHUNKS];
        for (genvar gk = 0; gk < NUM_CHUNKS; gk++) begin : g_chunk
            assign chunks[gk] = net_q[gi*GROUP_SIZE + gk*CHUNK_W +: CHUNK_W];
        end
        chunk_popcount #(.W(CHUNK_W)) u_popcount (
            .bits_i  (chunks[chunk_q]),
            .count_o (pc[gi])
        );
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_idx   = '0;
        best_score = acc_q[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (acc_q[c] > best_score) begin
                best_score = acc_q[c];
                best_idx   = IDX_W'(c);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_fire) state_d = COUNT;
            COUNT:   if (chunk_q == CHK_W'(NUM_CHUNKS - 1)) state_d = AVG;
            AVG:     state_d = ARG;
            ARG:     state_d = OUT;
            OUT:     if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            net_q       <= '0;
            chunk_q     <= '0;
            class_idx_q <= '0;
            onehot_q    <= '0;
            score_q     <= '0;
            out_valid_q <= 1'b0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                count_q[c] <= '0;
                acc_q[c]   <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        net_q   <= net_i;
                        chunk_q <= '0;
                        for (int c = 0; c < NUM_CLASSES; c++) count_q[c] <= '0;
                    end
                end
                COUNT: begin
                    chunk_q <= chunk_q + 1'b1;
                    for (int c = 0; c < NUM_CLASSES; c++) begin
                        count_q[c] <= count_q[c] + CNT_W'(pc[c]);
                    end
                end
                ARG: begin
                    class_idx_q <= best_idx;
                    onehot_q    <= NUM_CLASSES'(1) << best_idx;
                    score_q     <= best_score;
                    out_valid_q <= 1'b1;
                end
                OUT: begin
                    if (out_ready_i) out_valid_q <= 1'b0;
                end
                default: ;
            endcase

            // A clear on the AVG edge restarts the average from this sample's count.
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (clear_i) begin
                    acc_q[c] <= (state_q == AVG) ? ACC_W'(count_q[c]) : '0;
                end else if (state_q == AVG) begin
                    acc_q[c] <= acc_q[c] - (acc_q[c] >> MA_SHIFT) + ACC_W'(count_q[c]);
                end
            end
        end
    end

endmodule

// File: tb/tb_streaming_group_sum_classifier.sv
// Drives two classifier instances (EMA shift 2 and 0) with shared stimulus and checks
// both against a per-sample arithmetic model of counts, moving averages and argmax.
module tb_streaming_group_sum_classifier;

    localparam int NW = 8000;
    localparam int NC = 10;
    localparam int NK = 8;
    localparam int GS = NW / NC;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NW-1:0] net_in = '0;
    logic          inp_valid = 1'b0;
    logic          clear = 1'b0;
    logic          out_ready = 1'b0;

    logic [IW-1:0] idx2, idx0;
    logic [NC-1:0] oh2, oh0;
    logic [15:0]   sc2, sc0;
    logic          ov2, ov0, ir2, ir0;

    int checks = 0;
    int errors = 0;

    // Model state: index 0 is the shift-2 instance, index 1 the shift-0 instance.
    int acc_m [2][NC];
    int shift_m [2] = '{2, 0};
    int exp_idx [2];
    int exp_sc [2];

    always #5 clk = ~clk;

    streaming_group_sum_classifier #(.MA_SHIFT(2)) u_dut2 (
        .clk_i(clk), .reset_ni(reset_n), .net_i(net_in), .inp_valid_i(inp_valid),
        .inp_ready_o(ir2), .clear_i(clear), .class_idx_o(idx2), .class_onehot_o(oh2),
        .score_o(sc2), .out_valid_o(ov2), .out_ready_i(out_ready)
    );

    streaming_group_sum_classifier #(.MA_SHIFT(0)) u_dut0 (
        .clk_i(clk), .reset_ni(reset_n), .net_i(net_in), .inp_valid_i(inp_valid),
        .inp_ready_o(ir0), .clear_i(clear), .class_idx_o(idx0), .class_onehot_o(oh0),
        .score_o(sc0), .out_valid_o(ov0), .out_ready_i(out_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NW-1:0] class_ones(input int c);
        logic [NW-1:0] v = '0;
        for (int i = 0; i < GS; i++) v[c*GS + i] = 1'b1;
        return v;
    endfunction

    function automatic int grp_count(input logic [NW-1:0] v, input int c);
        int n = 0;
        for (int i = 0; i < GS; i++) n += int'(v[c*GS + i]);
        return n;
    endfunction

    function automatic logic [NC-1:0] onehot_of(input int i);
        logic [NC-1:0] v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_zero();
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < NC; c++) acc_m[m][c] = 0;
    endtask

    task automatic clear_in_idle();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        model_zero();
    endtask

    // clear_pos: 0 none, 1 mid-COUNT, 2 on AVG edge, 3 on ARG edge, 4 first OUT stall cycle.
    task automatic run_sample(input logic [NW-1:0] net, input int clear_pos, input int hold,
                              input string tag);
        int cnt [NC];
        for (int c = 0; c < NC; c++) cnt[c] = grp_count(net, c);

        @(negedge clk);
        check({tag, "_ready"}, ir2, 1);
        net_in    = net;
        inp_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inp_valid = 1'b0;
        net_in    = ~net;

        for (int k = 1; k <= NK + 2; k++) begin
            clear = (clear_pos == 1 && k == 3) || (clear_pos == 2 && k == NK + 1) ||
                    (clear_pos == 3 && k == NK + 2);
            @(posedge clk);
            @(negedge clk);
            clear = 1'b0;
            if (k == NK + 1) check({tag, "_early"}, ov2, 0);
        end
        check({tag, "_valid2"}, ov2, 1);
        check({tag, "_valid0"}, ov0, 1);

        for (int m = 0; m < 2; m++) begin
            exp_idx[m] = 0;
            for (int c = 0; c < NC; c++) begin
                if (clear_pos == 1) acc_m[m][c] = 0;
                if (clear_pos == 2) acc_m[m][c] = cnt[c];
                else acc_m[m][c] = acc_m[m][c] - (acc_m[m][c] >> shift_m[m]) + cnt[c];
            end
            for (int c = 1; c < NC; c++)
                if (acc_m[m][c] > acc_m[m][exp_idx[m]]) exp_idx[m] = c;
            exp_sc[m] = acc_m[m][exp_idx[m]];
        end

        check({tag, "_idx2"}, idx2, exp_idx[0]);
        check({tag, "_oh2"}, oh2, onehot_of(exp_idx[0]));
        check({tag, "_sc2"}, sc2, exp_sc[0]);
        check({tag, "_idx0"}, idx0, exp_idx[1]);
        check({tag, "_oh0"}, oh0, onehot_of(exp_idx[1]));
        check({tag, "_sc0"}, sc0, exp_sc[1]);

        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            inp_valid = 1'b1;
            net_in    = class_ones(h % NC);
            clear     = (clear_pos == 4 && h == 0);
            @(posedge clk);
            @(negedge clk);
            clear = 1'b0;
            check({tag, "_hold_valid"}, ov2, 1);
            check({tag, "_hold_ready"}, ir2, 0);
            check({tag, "_hold_idx"}, idx2, exp_idx[0]);
            check({tag, "_hold_sc"}, sc2, exp_sc[0]);
        end
        if (clear_pos == 3 || clear_pos == 4) model_zero();

        inp_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_done_valid"}, ov2, 0);
        check({tag, "_done_ready"}, ir2, 1);
        check({tag, "_kept_sc2"}, sc2, exp_sc[0]);
        check({tag, "_kept_sc0"}, sc0, exp_sc[1]);
        $display("sample %s: idx %0d/%0d score %0d/%0d clear_pos %0d hold %0d",
                 tag, idx2, idx0, sc2, sc0, clear_pos, hold);
    endtask

    initial begin
        logic [NW-1:0] rnet;
        int mode, pos, hold;

        model_zero();
        repeat (3) @(negedge clk);
        check("rst_valid", ov2, 0);
        check("rst_ready_low", ir2, 0);
        check("rst_idx", idx2, 0);
        check("rst_oh", oh2, 0);
        check("rst_score", sc2, 0);
        reset_n = 1'b1;

        run_sample('0, 0, 0, "zero");
        check("zero_idx", idx2, 0);
        check("zero_oh", oh2, 10'b0000000001);
        check("zero_score", sc2, 0);

        run_sample(class_ones(3), 0, 0, "cls3");
        check("bypass_idx", idx0, 3);
        check("bypass_oh", oh0, 10'b0000001000);
        check("bypass_score", sc0, 800);

        clear_in_idle();
        run_sample(class_ones(5), 0, 0, "c5a");
        check("ema_s1", sc2, 800);
        run_sample(class_ones(5), 0, 0, "c5b");
        check("ema_s2", sc2, 1400);
        run_sample(class_ones(5), 0, 0, "c5c");
        check("ema_s3", sc2, 1850);
        run_sample(class_ones(7), 0, 0, "c7");
        check("ema_idx", idx2, 5);
        check("ema_decay", sc2, 1388);

        run_sample(class_ones(1) | class_ones(8), 0, 5, "stall");

        clear_in_idle();
        run_sample(class_ones(2), 0, 0, "clr2");
        check("clear_idx", idx2, 2);
        check("clear_score", sc2, 800);
        run_sample(class_ones(2), 0, 0, "c2b");
        run_sample(class_ones(2), 0, 0, "c2c");

        @(negedge clk);
        net_in    = class_ones(4);
        inp_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inp_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", ov2, 0);
        check("midrst_ready", ir2, 0);
        check("midrst_score", sc2, 0);
        reset_n = 1'b1;
        model_zero();
        run_sample(class_ones(9), 0, 0, "c9");
        check("after_rst_idx", idx2, 9);
        check("after_rst_score", sc2, 800);

        for (int s = 0; s < 14; s++) begin
            for (int c = 0; c < NC; c++) begin
                mode = $urandom_range(0, 3);
                for (int i = 0; i < GS; i++) begin
                    case (mode)
                        0: rnet[c*GS + i] = 1'b0;
                        1: rnet[c*GS + i] = 1'b1;
                        2: rnet[c*GS + i] = 1'($urandom_range(0, 1));
                        default: rnet[c*GS + i] = ($urandom_range(0, 7) == 0);
                    endcase
                end
            end
            pos  = $urandom_range(0, 4);
            hold = $urandom_range(0, 3);
            if (pos == 4 && hold == 0) hold = 1;
            run_sample(rnet, pos, hold, $sformatf("rnd%0d", s));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
